// File: rtl/mem_wb_elastic.sv
// rtl/mem_wb_elastic.sv - MEM/WB two-entry elastic stage with flush, x0 suppression and stall counter
module mem_wb_elastic #(
   parameter int DATA_W      = 64,
   parameter int RD_W        = 5,
   parameter int CNT_W       = 16,
   parameter int SUPPRESS_X0 = 1
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [RD_W-1:0]   in_rd,
   input  logic [DATA_W-1:0] in_alu,
   input  logic [DATA_W-1:0] in_rdata,
   input  logic              in_regwrite,
   input  logic              in_memtoreg,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [RD_W-1:0]   out_rd,
   output logic [DATA_W-1:0] out_alu,
   output logic [DATA_W-1:0] out_rdata,
   output logic              out_regwrite,
   output logic              out_memtoreg,
   output logic [DATA_W-1:0] out_wb_data,
   output logic [1:0]        occupancy,
   output logic [CNT_W-1:0]  stall_cnt
);

   logic              h_valid, s_valid;
   logic [RD_W-1:0]   h_rd, s_rd;
   logic [DATA_W-1:0] h_alu, s_alu, h_rdata, s_rdata;
   logic              h_regwrite, s_regwrite, h_memtoreg, s_memtoreg;

   logic accept, pop, cap_regwrite;

   // in_ready depends only on the skid slot, so there is no out_ready -> in_ready path
   assign in_ready     = !s_valid;
   assign accept       = in_valid & in_ready;
   assign pop          = h_valid & out_ready;
   assign cap_regwrite = in_regwrite & ((SUPPRESS_X0 == 0) || (in_rd != '0));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         h_valid    <= 1'b0;
         h_rd       <= '0;
         h_alu      <= '0;
         h_rdata    <= '0;
         h_regwrite <= 1'b0;
         h_memtoreg <= 1'b0;
         s_valid    <= 1'b0;
         s_rd       <= '0;
         s_alu      <= '0;
         s_rdata    <= '0;
         s_regwrite <= 1'b0;
         s_memtoreg <= 1'b0;
      end else if (flush) begin
         h_valid    <= 1'b0;
         h_regwrite <= 1'b0;
         h_memtoreg <= 1'b0;
         s_valid    <= 1'b0;
         s_regwrite <= 1'b0;
         s_memtoreg <= 1'b0;
      end else if (s_valid) begin
         if (pop) begin
            h_rd       <= s_rd;
            h_alu      <= s_alu;
            h_rdata    <= s_rdata;
            h_regwrite <= s_regwrite;
            h_memtoreg <= s_memtoreg;
            s_valid    <= 1'b0;
         end
      end else if (h_valid && accept && !pop) begin
         s_valid    <= 1'b1;
         s_rd       <= in_rd;
         s_alu      <= in_alu;
         s_rdata    <= in_rdata;
         s_regwrite <= cap_regwrite;
         s_memtoreg <= in_memtoreg;
      end else if (accept) begin
         // EMPTY, or ONE with a simultaneous pop: the new beat becomes the head
         h_valid    <= 1'b1;
         h_rd       <= in_rd;
         h_alu      <= in_alu;
         h_rdata    <= in_rdata;
         h_regwrite <= cap_regwrite;
         h_memtoreg <= in_memtoreg;
      end else if (pop) begin
         h_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         stall_cnt <= '0;
      end else if (h_valid && !out_ready && (stall_cnt != {CNT_W{1'b1}})) begin
         stall_cnt <= stall_cnt + CNT_W'(1);
      end
   end

   assign out_valid    = h_valid;
   assign out_rd       = h_rd;
   assign out_alu      = h_alu;
   assign out_rdata    = h_rdata;
   assign out_regwrite = h_regwrite & h_valid;
   assign out_memtoreg = h_memtoreg;
   assign out_wb_data  = h_memtoreg ? h_rdata : h_alu;
   assign occupancy    = {1'b0, h_valid} + {1'b0, s_valid};

endmodule

// File: doc/mem_wb_elastic.md
Name: mem_wb_elastic

Overview:
- Next-generation MEM/WB pipeline stage.
- Replaces the fixed always-advancing register with a parametrised two-entry elastic (skid) buffer using valid/ready handshakes on both sides.
- Adds synchronous flush, x0-write suppression, a muxed writeback-data output and a saturating back-pressure counter.
- Sits between the data-memory stage and register-file write port, so the WB side can stall without losing in-flight results.

Parameters:
- DATA_W, 64, width of ALU result and memory read data.
- RD_W, 5, destination register index width.
- CNT_W, 16, width of stall counter.
- SUPPRESS_X0, 1, when 1 a beat with rd==0 is captured with regwrite forced to 0.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous active-low reset.
- flush  input  1  synchronous kill of all held entries.
- in_valid  input  1  upstream beat present.
- in_ready  output  1  stage can accept a beat this cycle.
- in_rd  input  RD_W  destination register.
- in_alu  input  DATA_W  ALU result.
- in_rdata  input  DATA_W  memory read data.
- in_regwrite  input  1  write-enable control.
- in_memtoreg  input  1  select read data for writeback.
- out_valid  output  1  head entry valid.
- out_ready  input  1  downstream consumes head this cycle.
- out_rd  output  RD_W  head rd.
- out_alu  output  DATA_W  head ALU result.
- out_rdata  output  DATA_W  head read data.
- out_regwrite  output  1  head regwrite AND out_valid.
- out_memtoreg  output  1  head memtoreg.
- out_wb_data  output  DATA_W  out_memtoreg ? out_rdata : out_alu (combinational from head register).
- occupancy  output  2  number of held entries, 0..2.
- stall_cnt  output  CNT_W  saturating count of back-pressured cycles.

Behaviour:
- Reset (reset_n low, asynchronous): all head and skid fields 0; both valid bits 0; stall_cnt 0. Consequently out_valid=0, out_regwrite=0, out_wb_data=0, occupancy=0, in_ready=1.
- Storage: head register H drives outputs; skid register S.
- State is encoded by valid bits: EMPTY (H=0, S=0), ONE (H=1, S=0), FULL (H=1, S=1).
- in_ready = !S_valid. It is registered state only, with no combinational path from out_ready.
- accept = in_valid & in_ready. pop = out_valid & out_ready.
- Transitions, when flush=0:
  - EMPTY: accept -> ONE, H<=in.
  - ONE: accept & pop -> ONE, H<=in. accept & !pop -> FULL, S<=in. !accept & pop -> EMPTY. Else hold.
  - FULL: pop -> ONE, H<=S. Else hold. No accept is possible.
- Latency: a beat accepted in cycle N appears on outputs in cycle N+1 when the stage was EMPTY, or after pop of H. Throughput is 1 beat/cycle with out_ready held high.
- Order: strictly FIFO. S is never presented before H.
- Flush: highest priority among synchronous events. Next state is EMPTY regardless of accept/pop. A beat offered in the flush cycle is dropped, and in_ready is unaffected that cycle. Data fields may retain old values; control (regwrite, memtoreg) of H and S clears to 0.
- SUPPRESS_X0=1: captured regwrite = in_regwrite & (in_rd != 0). The rest of the beat is stored unchanged.
- stall_cnt: increments by 1 each cycle with out_valid & !out_ready. It saturates at 2^CNT_W-1, is not cleared by flush, and is cleared only by reset.
- Reset asserted mid-transfer: immediately empties both entries. No beat is recoverable.
- out_regwrite is never 1 while out_valid=0.

Test Plan:
- Reset and pass-through: reset_n=0 then 1, out_ready=1, stream 4 beats alu=0x10..0x13, rd=1..4, regwrite=1 -> each appears 1 cycle after accept, occupancy<=1, in_ready stays 1, stall_cnt=0.
- Back-pressure: out_ready=0, offer beats A(alu=0xA), B(0xB), C(0xC) on consecutive cycles -> A,B accepted, in_ready=0 when C is offered, occupancy=2. Release out_ready -> A, B, C emerge in order. stall_cnt equals the back-pressured cycle count.
- Writeback mux: beat alu=0x1234, rdata=0xBEEF, memtoreg=1 -> out_wb_data=0xBEEF. Same beat with memtoreg=0 -> 0x1234.
- x0 suppression: beat rd=0, regwrite=1 -> out_regwrite=0 with out_valid=1. With SUPPRESS_X0=0 -> out_regwrite=1.
- Flush while FULL with in_valid=1 -> next cycle occupancy=0, out_valid=0, out_regwrite=0, in_ready=1, offered beat never appears. stall_cnt is unchanged.
- Async reset mid-FULL, asserted between clock edges -> outputs go to 0 immediately. stall_cnt=0. Saturation check: CNT_W=4, hold out_ready=0 for 20 cycles -> stall_cnt=15.
